// File: rtl/branch_predict_ctrl.sv
// branch_predict_ctrl: bimodal BHT branch predictor with EX-stage misprediction recovery
module branch_predict_ctrl #(
  parameter int XLEN = 32,
  parameter int INDEX_BITS = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] if_pc,
  input  logic            if_is_branch,
  input  logic [XLEN-1:0] if_target,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_pc,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_zero,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_target,
  input  logic            ex_pred_taken,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic            if_id_flush,
  output logic            id_ex_flush,
  output logic [31:0]     branch_cnt,
  output logic [31:0]     mispred_cnt
);
  logic [1:0] bht [2**INDEX_BITS];
  logic [INDEX_BITS-1:0] if_idx, ex_idx;
  logic [1:0] ex_ctr;
  logic actual_taken, mispredict, train;
  assign if_idx = if_pc[INDEX_BITS+1:2];
  assign ex_idx = ex_pc[INDEX_BITS+1:2];
  assign ex_ctr = bht[ex_idx];
  always_comb begin
    pred_taken = if_is_branch & bht[if_idx][1];
    pred_pc = pred_taken ? if_target : if_pc + XLEN'(4);
    actual_taken = ex_jump | (ex_branch & ex_zero);
    train = ex_valid & ex_branch;
    mispredict = train & (actual_taken != ex_pred_taken);
    redirect = mispredict | (ex_valid & ex_jump);
    redirect_pc = actual_taken ? ex_target : ex_pc + XLEN'(4);
    if_id_flush = redirect;
    id_ex_flush = redirect;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2**INDEX_BITS; i++) bht[i] <= 2'b01;
      branch_cnt <= '0;
      mispred_cnt <= '0;
    end else begin
      if (train)
        bht[ex_idx] <= actual_taken ? (ex_ctr == 2'b11 ? ex_ctr : ex_ctr + 2'b01)
                                    : (ex_ctr == 2'b00 ? ex_ctr : ex_ctr - 2'b01);
      branch_cnt <= branch_cnt + 32'(train);
      mispred_cnt <= mispred_cnt + 32'(mispredict);
    end
  end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// tb_branch_predict_ctrl: directed bench with a behavioural predictor model checked every cycle
module tb_branch_predict_ctrl;
  logic        clk = 0;
  logic        rst_n;
  logic [31:0] if_pc, if_target, ex_pc, ex_target;
  logic        if_is_branch, ex_valid, ex_branch, ex_jump, ex_zero, ex_pred_taken;
  logic        pred_taken, redirect, if_id_flush, id_ex_flush;
  logic [31:0] pred_pc, redirect_pc, branch_cnt, mispred_cnt;
  int total = 0, bad = 0;
  int m_bht [64];
  logic [31:0] m_bc, m_mc;
  bit live = 0;

  branch_predict_ctrl #(.XLEN(32), .INDEX_BITS(6)) dut (
    .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_is_branch(if_is_branch), .if_target(if_target),
    .pred_taken(pred_taken), .pred_pc(pred_pc), .ex_valid(ex_valid), .ex_branch(ex_branch),
    .ex_jump(ex_jump), .ex_zero(ex_zero), .ex_pc(ex_pc), .ex_target(ex_target),
    .ex_pred_taken(ex_pred_taken), .redirect(redirect), .redirect_pc(redirect_pc),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .branch_cnt(branch_cnt),
    .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 4) % 64);
  endfunction

  // reference model: counters as plain integers clamped to 0..3
  always @(posedge clk) begin
    live <= 1;
    if (!rst_n) begin
      foreach (m_bht[i]) m_bht[i] = 1;
      m_bc = 0;
      m_mc = 0;
    end else if (ex_valid && ex_branch) begin
      automatic bit taken = ex_jump || ex_zero;
      automatic int k = idx_of(ex_pc);
      m_bht[k] = taken ? ((m_bht[k] < 3) ? m_bht[k] + 1 : 3) : ((m_bht[k] > 0) ? m_bht[k] - 1 : 0);
      m_bc = m_bc + 1;
      if (taken != ex_pred_taken) m_mc = m_mc + 1;
    end
  end

  always @(negedge clk) if (live) begin
    automatic bit ep = if_is_branch && (m_bht[idx_of(if_pc)] >= 2);
    automatic bit taken = ex_jump || (ex_branch && ex_zero);
    automatic bit mis = ex_valid && ex_branch && (taken != ex_pred_taken);
    automatic bit rd = mis || (ex_valid && ex_jump);
    chk("pred_taken", 32'(pred_taken), 32'(ep));
    chk("pred_pc", pred_pc, ep ? if_target : if_pc + 4);
    chk("redirect", 32'(redirect), 32'(rd));
    chk("redirect_pc", redirect_pc, taken ? ex_target : ex_pc + 4);
    chk("if_id_flush", 32'(if_id_flush), 32'(rd));
    chk("id_ex_flush", 32'(id_ex_flush), 32'(rd));
    chk("branch_cnt", branch_cnt, m_bc);
    chk("mispred_cnt", mispred_cnt, m_mc);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ex_set(input bit v, input bit b, input bit j, input bit z, input bit p,
                        input logic [31:0] pc, input logic [31:0] tgt);
    ex_valid = v; ex_branch = b; ex_jump = j; ex_zero = z; ex_pred_taken = p;
    ex_pc = pc; ex_target = tgt;
  endtask

  initial begin
    rst_n = 0;
    if_pc = 0; if_is_branch = 0; if_target = 0;
    ex_set(0, 0, 0, 0, 0, 0, 0);
    tick;
    tick;
    rst_n = 1;
    if_pc = 32'h100; if_is_branch = 1; if_target = 32'h140;
    @(negedge clk);
    chk("lit_reset_pred", 32'(pred_taken), 0);
    chk("lit_reset_pred_pc", pred_pc, 32'h104);
    chk("lit_reset_bcnt", branch_cnt, 0);
    chk("lit_reset_mcnt", mispred_cnt, 0);
    tick;
    ex_set(1, 1, 0, 1, 0, 32'h100, 32'h140);
    @(negedge clk);
    chk("lit_collision_pred", 32'(pred_taken), 0);
    chk("lit_first_redirect_pc", redirect_pc, 32'h140);
    tick;
    ex_pred_taken = 1;
    @(negedge clk);
    chk("lit_trained_pred", 32'(pred_taken), 1);
    chk("lit_trained_pred_pc", pred_pc, 32'h140);
    tick;
    tick;
    ex_valid = 0;
    if_pc = 32'h200; if_target = 32'h240;
    @(negedge clk);
    chk("lit_alias_pred", 32'(pred_taken), 1);
    chk("lit_sat_bcnt", branch_cnt, 3);
    chk("lit_sat_mcnt", mispred_cnt, 1);
    tick;
    ex_set(1, 1, 0, 0, 1, 32'h200, 32'h240);
    @(negedge clk);
    chk("lit_mis_redirect", 32'(redirect), 1);
    chk("lit_mis_redirect_pc", redirect_pc, 32'h204);
    chk("lit_mis_flush", 32'({if_id_flush, id_ex_flush}), 3);
    tick;
    ex_valid = 0;
    @(negedge clk);
    chk("lit_mis_next_redirect", 32'(redirect), 0);
    tick;
    ex_set(1, 0, 1, 0, 0, 32'h300, 32'h80);
    @(negedge clk);
    chk("lit_jump_redirect", 32'(redirect), 1);
    chk("lit_jump_redirect_pc", redirect_pc, 32'h80);
    tick;
    ex_set(0, 0, 0, 0, 0, 32'h300, 32'h80);
    if_pc = 32'h300; if_target = 32'h380;
    @(negedge clk);
    chk("lit_jump_entry", 32'(pred_taken), 1);
    chk("lit_jump_bcnt", branch_cnt, 4);
    chk("lit_jump_mcnt", mispred_cnt, 2);
    tick;
    ex_set(0, 1, 0, 0, 1, 32'h100, 32'h140);
    @(negedge clk);
    chk("lit_bubble_redirect", 32'(redirect), 0);
    tick;
    @(negedge clk);
    chk("lit_bubble_entry", 32'(pred_taken), 1);
    chk("lit_bubble_bcnt", branch_cnt, 4);
    tick;
    ex_set(0, 0, 0, 0, 0, 0, 0);
    force dut.branch_cnt = 32'hFFFF_FFFF;
    m_bc = 32'hFFFF_FFFF;
    #1 release dut.branch_cnt;
    @(negedge clk);
    chk("lit_wrap_preload", branch_cnt, 32'hFFFF_FFFF);
    tick;
    ex_set(1, 1, 0, 1, 1, 32'h400, 32'h500);
    tick;
    ex_valid = 0;
    @(negedge clk);
    chk("lit_wrap_bcnt", branch_cnt, 0);
    chk("lit_wrap_mcnt", mispred_cnt, 2);
    for (int i = 0; i < 16; i++) begin
      tick;
      if_pc = 32'h1000 + 32'(4 * (i % 5));
      if_target = 32'h2000 + 32'(i * 8);
      if_is_branch = (i % 3) != 2;
      ex_set((i % 5) != 4, (i % 4) != 2, (i % 7) == 3, i[0], i[1],
             32'h1000 + 32'(4 * ((i + 1) % 5)), 32'h3000 + 32'(i * 16));
    end
    tick;
    ex_set(1, 1, 0, 1, 0, 32'h100, 32'h140);
    if_pc = 32'h100; if_target = 32'h140; if_is_branch = 1;
    rst_n = 0;
    tick;
    rst_n = 1;
    ex_valid = 0;
    @(negedge clk);
    chk("lit_midreset_pred", 32'(pred_taken), 0);
    chk("lit_midreset_bcnt", branch_cnt, 0);
    tick;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
